// File: rtl/stdp_lif_net_if.sv
// Host-side bundle for stdp_lif_net: currents/learning/weight-write in, spikes/state/weights out.
// No handshake: every signal is sampled or presented once per core cycle.
interface stdp_lif_net_if #(
   parameter int N_PRE  = 2,
   parameter int V_BITS = 8,
   parameter int W_BITS = 4,
   parameter int IDX_W  = (N_PRE > 1) ? $clog2(N_PRE) : 1
);
   logic                      learn_en;
   logic [N_PRE*V_BITS-1:0]   cur_in;
   logic                      wt_wr;
   logic [IDX_W-1:0]          wt_idx;
   logic [W_BITS-1:0]         wt_data;
   logic [N_PRE-1:0]          pre_spike;
   logic                      post_spike;
   logic [V_BITS-1:0]         post_state;
   logic [N_PRE*W_BITS-1:0]   weights;

   modport master (
      output learn_en, cur_in, wt_wr, wt_idx, wt_data,
      input  pre_spike, post_spike, post_state, weights
   );

   modport slave (
      input  learn_en, cur_in, wt_wr, wt_idx, wt_data,
      output pre_spike, post_spike, post_state, weights
   );
endinterface

// File: rtl/stdp_lif_net.sv
// N_PRE LIF neurons feeding one LIF neuron through STDP-learned weights; spikes 1 edge after current.
// No backpressure: inputs are consumed and outputs refreshed every cycle, host writes always win.
module stdp_lif_net #(
   parameter int N_PRE      = 2,
   parameter int V_BITS     = 8,
   parameter int W_BITS     = 4,
   parameter int THRESH     = 200,
   parameter int LEAK_SHIFT = 2,
   parameter int REFRAC     = 2,
   parameter int W_SHIFT    = 4,
   parameter int WINDOW     = 7,
   parameter int W_INIT     = 8,
   parameter int LTP_STEP   = 1,
   parameter int LTD_STEP   = 1
) (
   input  logic          clk,
   input  logic          rst,
   stdp_lif_net_if.slave bus
);

   localparam int IDX_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;
   localparam int AGE_W = (WINDOW > 0) ? $clog2(WINDOW + 1) : 1;
   localparam int R_W   = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int PC_W  = ((V_BITS > W_BITS + W_SHIFT) ? V_BITS : W_BITS + W_SHIFT) + 4;
   localparam int W_MAX = (1 << W_BITS) - 1;

   typedef struct packed {
      logic [V_BITS-1:0] v;
      logic [R_W-1:0]    r;
      logic              spk;
   } nrn_t;

   nrn_t              pre_q      [N_PRE];
   nrn_t              pre_d      [N_PRE];
   nrn_t              post_q;
   nrn_t              post_d;
   logic [AGE_W-1:0]  pre_age_q  [N_PRE];
   logic [AGE_W-1:0]  pre_age_d  [N_PRE];
   logic [AGE_W-1:0]  post_age_q;
   logic [AGE_W-1:0]  post_age_d;
   logic [W_BITS-1:0] w_q        [N_PRE];
   logic [W_BITS-1:0] w_d        [N_PRE];

   logic [PC_W-1:0]   pc_sum;
   logic [V_BITS-1:0] post_cur;
   logic [N_PRE-1:0]  wr_hit;
   logic [N_PRE-1:0]  ltp;
   logic [N_PRE-1:0]  ltd;
   logic [N_PRE-1:0]        pre_spike_dat;
   logic [N_PRE*W_BITS-1:0] weights_dat;

   // The sum is one bit wider than v, so a carry out means saturate.
   function automatic nrn_t lif_step(input nrn_t cur, input logic [V_BITS-1:0] i_in);
      nrn_t          nxt;
      logic [V_BITS:0] sum;
      nxt = cur;
      sum = '0;
      if (cur.r != '0) begin
         nxt.v   = '0;
         nxt.r   = cur.r - R_W'(1);
         nxt.spk = 1'b0;
      end else begin
         sum = {1'b0, cur.v} - {1'b0, (cur.v >> LEAK_SHIFT)} + {1'b0, i_in};
         if (sum[V_BITS]) begin
            sum = {1'b0, {V_BITS{1'b1}}};
         end
         if (sum >= (V_BITS + 1)'(THRESH)) begin
            nxt.v   = '0;
            nxt.r   = R_W'(REFRAC);
            nxt.spk = 1'b1;
         end else begin
            nxt.v   = sum[V_BITS-1:0];
            nxt.r   = '0;
            nxt.spk = 1'b0;
         end
      end
      return nxt;
   endfunction

   function automatic logic [AGE_W-1:0] age_next(input logic spk, input logic [AGE_W-1:0] age);
      logic [AGE_W-1:0] nxt;
      nxt = age;
      if (spk) begin
         nxt = '0;
      end else if (age < AGE_W'(WINDOW)) begin
         nxt = age + AGE_W'(1);
      end
      return nxt;
   endfunction

   // Post current comes from the registered pre spikes of the current cycle.
   always_comb begin
      pc_sum = '0;
      for (int i = 0; i < N_PRE; i++) begin
         if (pre_q[i].spk) begin
            pc_sum = pc_sum + (PC_W'(w_q[i]) << W_SHIFT);
         end
      end
      post_cur = (pc_sum > PC_W'((1 << V_BITS) - 1)) ? {V_BITS{1'b1}} : pc_sum[V_BITS-1:0];
   end

   always_comb begin
      for (int i = 0; i < N_PRE; i++) begin
         pre_d[i]     = lif_step(pre_q[i], bus.cur_in[i*V_BITS +: V_BITS]);
         pre_age_d[i] = age_next(pre_q[i].spk, pre_age_q[i]);
      end
      post_d     = lif_step(post_q, post_cur);
      post_age_d = age_next(post_q.spk, post_age_q);
   end

   // A coincident pre/post spike lands in the LTP branch because LTD requires no post spike.
   always_comb begin
      wr_hit = '0;
      ltp    = '0;
      ltd    = '0;
      for (int i = 0; i < N_PRE; i++) begin
         wr_hit[i] = bus.wt_wr && (bus.wt_idx == IDX_W'(i));
         ltp[i]    = bus.learn_en && post_q.spk &&
                     (pre_q[i].spk || (pre_age_q[i] < AGE_W'(WINDOW)));
         ltd[i]    = bus.learn_en && !post_q.spk && pre_q[i].spk &&
                     (post_age_q < AGE_W'(WINDOW));
         w_d[i]    = w_q[i];
         if (wr_hit[i]) begin
            w_d[i] = bus.wt_data;
         end else if (ltp[i]) begin
            w_d[i] = (int'(w_q[i]) + LTP_STEP > W_MAX) ? W_BITS'(W_MAX)
                                                       : w_q[i] + W_BITS'(LTP_STEP);
         end else if (ltd[i]) begin
            w_d[i] = (int'(w_q[i]) < LTD_STEP) ? '0 : w_q[i] - W_BITS'(LTD_STEP);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_PRE; i++) begin
            pre_q[i]     <= '0;
            pre_age_q[i] <= AGE_W'(WINDOW);
            w_q[i]       <= W_BITS'(W_INIT);
         end
         post_q     <= '0;
         post_age_q <= AGE_W'(WINDOW);
      end else begin
         for (int i = 0; i < N_PRE; i++) begin
            pre_q[i]     <= pre_d[i];
            pre_age_q[i] <= pre_age_d[i];
            w_q[i]       <= w_d[i];
         end
         post_q     <= post_d;
         post_age_q <= post_age_d;
      end
   end

   always_comb begin
      pre_spike_dat = '0;
      weights_dat   = '0;
      for (int i = 0; i < N_PRE; i++) begin
         pre_spike_dat[i]                  = pre_q[i].spk;
         weights_dat[i*W_BITS +: W_BITS]   = w_q[i];
      end
   end

   assign bus.pre_spike  = pre_spike_dat;
   assign bus.post_spike = post_q.spk;
   assign bus.post_state = post_q.v;
   assign bus.weights    = weights_dat;

endmodule

// File: tb/tb_stdp_lif_net.sv
// Bench for stdp_lif_net: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a cycle-level arithmetic model of the neurons and learning rule.
module tb_stdp_lif_net;

   localparam int N_PRE      = 2;
   localparam int V_BITS     = 8;
   localparam int W_BITS     = 4;
   localparam int THRESH     = 200;
   localparam int LEAK_SHIFT = 2;
   localparam int REFRAC     = 2;
   localparam int W_SHIFT    = 4;
   localparam int WINDOW     = 7;
   localparam int W_INIT     = 8;
   localparam int LTP_STEP   = 1;
   localparam int LTD_STEP   = 1;
   localparam int V_MAX      = (1 << V_BITS) - 1;
   localparam int W_MAX      = (1 << W_BITS) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stdp_lif_net_if #(.N_PRE(N_PRE), .V_BITS(V_BITS), .W_BITS(W_BITS)) bus ();
   stdp_lif_net_if #(.N_PRE(3), .V_BITS(V_BITS), .W_BITS(W_BITS)) bus3 ();

   stdp_lif_net #(
      .N_PRE(N_PRE), .V_BITS(V_BITS), .W_BITS(W_BITS), .THRESH(THRESH),
      .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC), .W_SHIFT(W_SHIFT), .WINDOW(WINDOW),
      .W_INIT(W_INIT), .LTP_STEP(LTP_STEP), .LTD_STEP(LTD_STEP)
   ) dut (.clk(clk), .rst(rst), .bus(bus));

   stdp_lif_net #(
      .N_PRE(3), .V_BITS(V_BITS), .W_BITS(W_BITS), .THRESH(THRESH),
      .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC), .W_SHIFT(W_SHIFT), .WINDOW(WINDOW),
      .W_INIT(W_INIT), .LTP_STEP(LTP_STEP), .LTD_STEP(LTD_STEP)
   ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: plain integers, "cycles since last spike" saturating at WINDOW.
   int m_v [N_PRE], m_r [N_PRE], m_s [N_PRE], m_age [N_PRE], m_w [N_PRE];
   int p_v, p_r, p_s, p_age;

   task automatic lif(input int v, input int r, input int cur, output int nv, output int nr, output int ns);
      int s;
      if (r > 0) begin
         nv = 0; nr = r - 1; ns = 0;
      end else begin
         s = v - (v >> LEAK_SHIFT) + cur;
         if (s > V_MAX) s = V_MAX;
         if (s >= THRESH) begin
            nv = 0; nr = REFRAC; ns = 1;
         end else begin
            nv = s; nr = 0; ns = 0;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_PRE; i++) begin
         m_v[i] = 0; m_r[i] = 0; m_s[i] = 0; m_age[i] = WINDOW; m_w[i] = W_INIT;
      end
      p_v = 0; p_r = 0; p_s = 0; p_age = WINDOW;
   endtask

   task automatic model_step();
      int pc;
      int nv [N_PRE], nr [N_PRE], ns [N_PRE], na [N_PRE], nw [N_PRE];
      int npv, npr, nps, npa;
      pc = 0;
      for (int i = 0; i < N_PRE; i++)
         if (m_s[i] != 0) pc += m_w[i] * (1 << W_SHIFT);
      if (pc > V_MAX) pc = V_MAX;
      for (int i = 0; i < N_PRE; i++) begin
         lif(m_v[i], m_r[i], int'(bus.cur_in[i*V_BITS +: V_BITS]), nv[i], nr[i], ns[i]);
         na[i] = (m_s[i] != 0) ? 0 : ((m_age[i] + 1 > WINDOW) ? WINDOW : m_age[i] + 1);
         if (bus.wt_wr && int'(bus.wt_idx) == i)
            nw[i] = int'(bus.wt_data);
         else if (bus.learn_en && p_s != 0 && (m_s[i] != 0 || m_age[i] < WINDOW))
            nw[i] = (m_w[i] + LTP_STEP > W_MAX) ? W_MAX : m_w[i] + LTP_STEP;
         else if (bus.learn_en && m_s[i] != 0 && p_age < WINDOW)
            nw[i] = (m_w[i] - LTD_STEP < 0) ? 0 : m_w[i] - LTD_STEP;
         else
            nw[i] = m_w[i];
      end
      lif(p_v, p_r, pc, npv, npr, nps);
      npa = (p_s != 0) ? 0 : ((p_age + 1 > WINDOW) ? WINDOW : p_age + 1);
      for (int i = 0; i < N_PRE; i++) begin
         m_v[i] = nv[i]; m_r[i] = nr[i]; m_s[i] = ns[i]; m_age[i] = na[i]; m_w[i] = nw[i];
      end
      p_v = npv; p_r = npr; p_s = nps; p_age = npa;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   logic [N_PRE-1:0]        exp_pre;
   logic [N_PRE*W_BITS-1:0] exp_w;

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < N_PRE; i++) begin
            exp_pre[i]                  = (m_s[i] != 0);
            exp_w[i*W_BITS +: W_BITS]   = W_BITS'(m_w[i]);
         end
         chk("cmp_pre_spike",  32'(bus.pre_spike),  32'(exp_pre));
         chk("cmp_post_spike", 32'(bus.post_spike), 32'(p_s));
         chk("cmp_post_state", 32'(bus.post_state), 32'(p_v));
         chk("cmp_weights",    32'(bus.weights),    32'(exp_w));
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_idle();
      bus.learn_en = 1'b0; bus.cur_in = '0; bus.wt_wr = 1'b0; bus.wt_idx = '0; bus.wt_data = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic write_w(input int idx, input int data);
      bus.wt_wr = 1'b1; bus.wt_idx = 1'(idx); bus.wt_data = 4'(data);
      cyc();
      bus.wt_wr = 1'b0;
   endtask

   // Pre 1 drives a post spike, then pre 0 fires while that post spike is still recent.
   task automatic ltd_seq(input int w0_init, input int exp_w0);
      do_reset();
      bus.learn_en = 1'b1;
      write_w(1, 13);
      write_w(0, w0_init);
      bus.cur_in = 16'hFF00; cyc();
      bus.cur_in = '0;       cyc();
      chk("ltd_post_fires", 32'(bus.post_spike), 32'd1);
      cyc();
      chk("ltd_w1_ltp", 32'(bus.weights), 32'h0000_00E0 | 32'(w0_init));
      bus.cur_in = 16'h00FF; cyc();
      bus.cur_in = '0;       cyc();
      chk("ltd_weights", 32'(bus.weights), 32'h0000_00E0 | 32'(exp_w0));
   endtask

   initial begin
      logic [7:0] exp_ltp [3];
      exp_ltp[0] = 8'h8E; exp_ltp[1] = 8'h8F; exp_ltp[2] = 8'h8F;
      bus3.learn_en = 1'b0; bus3.cur_in = '0; bus3.wt_wr = 1'b0; bus3.wt_idx = '0; bus3.wt_data = '0;

      // Reset holds everything while high, regardless of inputs.
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.learn_en = 1'($urandom_range(0, 1));
         bus.cur_in   = 16'($urandom);
         bus.wt_wr    = 1'($urandom_range(0, 1));
         bus.wt_idx   = 1'($urandom_range(0, 1));
         bus.wt_data  = 4'($urandom);
         cyc();
         chk("rst_pre_spike",  32'(bus.pre_spike),  32'd0);
         chk("rst_post_spike", 32'(bus.post_spike), 32'd0);
         chk("rst_post_state", 32'(bus.post_state), 32'd0);
         chk("rst_weights",    32'(bus.weights),    32'h88);
      end
      set_idle();
      rst = 1'b0;
      cmp_en = 1'b1;

      // Constant drive on pre 0 with learning off.
      bus.cur_in = 16'h00FF;
      cyc(); chk("const_e1_pre", 32'(bus.pre_spike), 32'd1);
      cyc(); chk("const_e2_post_state", 32'(bus.post_state), 32'd128);
             chk("const_e2_pre", 32'(bus.pre_spike), 32'd0);
      cyc(); chk("const_e3_post_state", 32'(bus.post_state), 32'd96);
      cyc(); chk("const_e4_post_state", 32'(bus.post_state), 32'd72);
             chk("const_e4_pre", 32'(bus.pre_spike), 32'd1);
      cyc(); chk("const_e5_post_state", 32'(bus.post_state), 32'd182);
             chk("const_weights", 32'(bus.weights), 32'h88);

      // Causal pairing: weight climbs to saturation.
      do_reset();
      bus.learn_en = 1'b1;
      write_w(0, 13);
      for (int rep = 0; rep < 3; rep++) begin
         bus.cur_in = 16'h00FF; cyc();
         chk("ltp_pre_fires", 32'(bus.pre_spike), 32'd1);
         bus.cur_in = '0; cyc();
         chk("ltp_post_fires", 32'(bus.post_spike), 32'd1);
         cyc();
         chk("ltp_weights", 32'(bus.weights), 32'(exp_ltp[rep]));
         if (rep == 0) chk("ltp_model_w0", 32'(m_w[0]), 32'd14);
         repeat (10) cyc();
      end

      // Anti-causal pairing, then the floor at zero.
      ltd_seq(8, 7);
      ltd_seq(0, 0);

      // Host write beats a coincident LTP on the same synapse only.
      do_reset();
      bus.learn_en = 1'b1;
      write_w(0, 13);
      bus.cur_in = 16'hFFFF; cyc();
      bus.cur_in = '0;       cyc();
      chk("wpri_post_fires", 32'(bus.post_spike), 32'd1);
      bus.wt_wr = 1'b1; bus.wt_idx = 1'b0; bus.wt_data = 4'd3;
      cyc();
      bus.wt_wr = 1'b0;
      chk("wpri_weights", 32'(bus.weights), 32'h93);

      // Out-of-range index is only expressible with a non-power-of-two fan-in.
      bus3.wt_wr = 1'b1; bus3.wt_idx = 2'd3; bus3.wt_data = 4'd5;
      cyc(); chk("idx_oob_ignored", 32'(bus3.weights), 32'h888);
      bus3.wt_idx = 2'd2;
      cyc(); chk("idx_last_written", 32'(bus3.weights), 32'h588);
      bus3.wt_wr = 1'b0;

      // Asynchronous reset in the middle of a refractory period.
      do_reset();
      write_w(0, 5);
      bus.cur_in = 16'h00FF; cyc();
      bus.cur_in = '0;       cyc();
      chk("arst_pre_state", 32'(bus.post_state), 32'd80);
      #2 rst = 1'b1;
      #1;
      chk("arst_pre_spike",  32'(bus.pre_spike),  32'd0);
      chk("arst_post_state", 32'(bus.post_state), 32'd0);
      chk("arst_weights",    32'(bus.weights),    32'h88);
      @(negedge clk);
      cyc();
      rst = 1'b0;

      // Randomized traffic, with occasional mid-cycle resets.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N_PRE; i++)
            bus.cur_in[i*V_BITS +: V_BITS] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         bus.learn_en = ($urandom_range(0, 7) != 0);
         bus.wt_wr    = ($urandom_range(0, 15) == 0);
         bus.wt_idx   = 1'($urandom_range(0, 1));
         bus.wt_data  = 4'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #($urandom_range(1, 4)) rst = 1'b1;
            cyc();
            rst = 1'b0;
         end else begin
            cyc();
         end
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
